// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder plus a registered carry, LSB first,
// one bit per clock, with valid/ready handshakes on operands and result.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ci_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             co_out
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and in_valid is only looked at in IDLE.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH:0]   sum_cat;
  logic [WIDTH-1:0] sum_next;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; written as a concat-and-drop so WIDTH=1 works.
  assign sum_cat  = {fa_s, sum_sh};
  assign sum_next = sum_cat[WIDTH:1];

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      carry   <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      sum_out <= '0;
      co_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= ci_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          carry  <= fa_co;
          sum_sh <= sum_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum_out <= sum_next;
            co_out  <= fa_co;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances, directed tables,
// hand-written corner sequences and random ops against an arithmetic model.

module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;

  logic       iv8, ir8, ci8, ov8, or8, co8;
  logic [7:0] a8, b8, s8;
  logic       iv1, ir1, ci1, ov1, or1, co1;
  logic [0:0] a1, b1, s1;

  int tests = 0;
  int failed = 0;

  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] exp_sum;
    logic       exp_co;
  } vec_t;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a_in(a8), .b_in(b8), .ci_in(ci8), .out_valid(ov8),
    .out_ready(or8), .sum_out(s8), .co_out(co8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .a_in(a1), .b_in(b1), .ci_in(ci1), .out_valid(ov1),
    .out_ready(or1), .sum_out(s1), .co_out(co1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input int hold, output logic [7:0] s, output logic co);
    int n;
    n = 0;
    while (!ir8 && n < 40) begin @(negedge clk); n++; end
    check("op8_in_ready", ir8, 1);
    iv8 = 1'b1; a8 = a; b8 = b; ci8 = ci;
    @(negedge clk);
    iv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    n = 0;
    while (!ov8 && n < 40) begin @(negedge clk); n++; end
    check("op8_latency", n, 8);
    s = s8; co = co8;
    repeat (hold) begin
      @(negedge clk);
      check("op8_hold", {ov8, ir8, co8, s8}, {1'b1, 1'b0, co, s});
    end
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    check("op8_valid_drop", ov8, 0);
  endtask

  task automatic do_op1(input logic a, input logic b, input logic ci,
                        output logic s, output logic co);
    int n;
    n = 0;
    while (!ir1 && n < 10) begin @(negedge clk); n++; end
    iv1 = 1'b1; a1 = a; b1 = b; ci1 = ci;
    @(negedge clk);
    iv1 = 1'b0; a1 = ~a; b1 = ~b; ci1 = ~ci;
    n = 0;
    while (!ov1 && n < 10) begin @(negedge clk); n++; end
    check("op1_latency", n, 1);
    s = s1[0]; co = co1;
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
  endtask

  initial begin
    vec_t       dir_tab[5];
    vec_t       w1_tab[8];
    logic [1:0] fa_truth[8];
    logic [7:0] s, ra, rb, first_s;
    logic       co, rci, first_co;
    logic [8:0] model, got;
    int         seen_valid, n_out, pushed, prev_cyc, cyc;
    bit         pending;

    dir_tab[0] = '{8'd3,   8'd5,   1'b0, 8'd8,   1'b0};
    dir_tab[1] = '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1};
    dir_tab[2] = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1};
    dir_tab[3] = '{8'd10,  8'd20,  1'b0, 8'd30,  1'b0};
    dir_tab[4] = '{8'd0,   8'd0,   1'b1, 8'd1,   1'b0};
    // Index is {b,a,ci}; values are {co,s} from the full-adder truth table.
    fa_truth = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      w1_tab[i] = '{8'(idx[1]), 8'(idx[2]), idx[0], 8'(fa_truth[i][0]), fa_truth[i][1]};
    end

    rst_n = 1'b0;
    iv8 = 0; a8 = 0; b8 = 0; ci8 = 0; or8 = 0;
    iv1 = 0; a1 = 0; b1 = 0; ci1 = 0; or1 = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", ir8, 0);
    check("rst_out_valid", ov8, 0);
    check("rst_sum_co", {co8, s8}, 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready8", ir8, 1);
    check("rel_in_ready1", ir1, 1);
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      do_op8(dir_tab[i].a, dir_tab[i].b, dir_tab[i].ci, 0, s, co);
      check($sformatf("dir_sum_%0d", i), s, dir_tab[i].exp_sum);
      check($sformatf("dir_co_%0d", i), co, dir_tab[i].exp_co);
    end

    for (int i = 0; i < 8; i++) begin
      logic s_1;
      do_op1(w1_tab[i].a[0], w1_tab[i].b[0], w1_tab[i].ci, s_1, co);
      check($sformatf("w1_sum_%0d", i), s_1, w1_tab[i].exp_sum[0]);
      check($sformatf("w1_co_%0d", i), co, w1_tab[i].exp_co);
    end

    // Backpressure: result held 5 cycles, a new in_valid meanwhile is ignored.
    iv8 = 1'b1; a8 = 8'd200; b8 = 8'd100; ci8 = 1'b0;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (8) @(negedge clk);
    check("bp_valid", ov8, 1);
    first_s = s8; first_co = co8;
    check("bp_sum", {first_co, first_s}, 9'd300);
    iv8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stable", {ov8, ir8, co8, s8}, {1'b1, 1'b0, first_co, first_s});
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    check("bp_release", {ov8, ir8}, 2'b01);
    do_op8(8'd10, 8'd20, 1'b0, 0, s, co);
    check("bp_next", {co, s}, 9'd30);

    // Reset after 3 bit edges aborts the operation.
    iv8 = 1'b1; a8 = 8'd50; b8 = 8'd60; ci8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_state", {ov8, ir8, co8, s8}, 0);
    rst_n = 1'b1;
    #1;
    check("midrst_ready", ir8, 1);
    seen_valid = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov8) seen_valid++;
    end
    check("midrst_no_valid", seen_valid, 0);
    do_op8(8'd100, 8'd27, 1'b1, 0, s, co);
    check("midrst_next", {co, s}, 9'd128);

    // Random ops with random backpressure against a+b+ci.
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rci = 1'($urandom_range(0, 1));
      model = 9'(ra) + 9'(rb) + 9'(rci);
      do_op8(ra, rb, rci, $urandom_range(0, 3), s, co);
      check($sformatf("rand_%0d", i), {co, s}, model);
    end

    // Back-to-back: in_valid and out_ready held high for 4 ops.
    exp_q.delete();
    n_out = 0; pushed = 0; prev_cyc = 0; pending = 0;
    a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    iv8 = 1'b1; or8 = 1'b1;
    for (cyc = 0; cyc < 80 && n_out < 4; cyc++) begin
      if (pending) begin
        pending = 0;
        if (pushed < 4) begin
          a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
        end else begin
          iv8 = 1'b0;
        end
      end
      if (iv8 && ir8) begin
        exp_q.push_back(9'(a8) + 9'(b8) + 9'(ci8));
        pushed++;
        pending = 1;
      end
      @(negedge clk);
      if (ov8) begin
        got = {co8, s8};
        if (exp_q.size() == 0) check("b2b_unexpected", got, 9'h1ff);
        else check($sformatf("b2b_res_%0d", n_out), got, exp_q.pop_front());
        if (n_out > 0) check("b2b_spacing", cyc - prev_cyc, 10);
        prev_cyc = cyc;
        n_out++;
      end
    end
    iv8 = 1'b0;
    check("b2b_count", n_out, 4);
    seen_valid = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov8) seen_valid++;
    end
    or8 = 1'b0;
    check("b2b_no_extra", seen_valid + exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
